// File: rtl/column_flattener.sv
// column_flattener
//   Turns one raycaster column record per transaction into SCREEN_HEIGHT
//   framebuffer writes. Each row is painted as ceiling, wall or floor. Wall
//   rows whose map value is TEX_BASE or above are textured: the block requests
//   a texel and waits for it before writing that row.
//
//   Optional build macro COLFLAT_SHADE_EN: wall pixels (plain and textured) of
//   columns with wallType=1 are halved (logical shift right by one). Ceiling
//   and floor pixels are never shaded. With the macro undefined, wallType has
//   no effect.
//
//   Ports
//     pixel_clk_in           clock
//     rst_in                 synchronous active-high reset
//     col_tvalid_in/tready   column handshake; col_tdata_in fields:
//                            [37:29] hcount, [28:21] lineHeight, [20] wallType,
//                            [19:16] mapData, [15:0] wallX
//     col_tlast_in           last column of the frame
//     fb_ready_to_switch_in  framebuffer swap readiness (2'b11 = ready)
//     tex_req_out            one-cycle texel request, with tex_id/wallx/yoff
//     tex_valid_in           texel available on tex_pixel_in (TEX_WAIT only)
//     pix_valid_out          framebuffer write strobe, with pix_addr/pix_data
//     pix_last_out           marks the final write (or empty pulse) of a frame
//
//   Every write is registered: the write decided at a clock edge appears on the
//   pix_* outputs during the following cycle. A textured row is written from
//   the edge at which tex_valid_in is sampled high.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | col_tready_out=1, waiting for a column record
//   FLATTEN   | one row per cycle; textured rows issue a texel request
//   TEX_WAIT  | waiting for tex_valid_in to write the current textured row
//   WAIT_SWAP | frame finished, waiting for fb_ready_to_switch_in == 2'b11

module column_flattener #(
    parameter int         SCREEN_WIDTH  = 320,
    parameter int         SCREEN_HEIGHT = 180,
    parameter int         PIXEL_WIDTH   = 8,
    parameter logic [7:0] CEIL_COLOR    = 8'h2a,
    parameter logic [7:0] FLOOR_COLOR   = 8'hdc,
    parameter logic [7:0] WALL1_COLOR   = 8'hff,
    parameter logic [7:0] WALL2_COLOR   = 8'h97,
    parameter int         TEX_BASE      = 3,
    localparam int        ADDR_W        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   col_tvalid_in,
    input  logic [37:0]            col_tdata_in,
    input  logic                   col_tlast_in,
    output logic                   col_tready_out,
    input  logic [1:0]             fb_ready_to_switch_in,
    output logic                   tex_req_out,
    output logic [3:0]             tex_id_out,
    output logic [15:0]            tex_wallx_out,
    output logic [8:0]             tex_yoff_out,
    input  logic                   tex_valid_in,
    input  logic [PIXEL_WIDTH-1:0] tex_pixel_in,
    output logic                   pix_valid_out,
    output logic [ADDR_W-1:0]      pix_addr_out,
    output logic [PIXEL_WIDTH-1:0] pix_data_out,
    output logic                   pix_last_out
);

    localparam logic [PIXEL_WIDTH-1:0] CEIL_PX  = PIXEL_WIDTH'(CEIL_COLOR);
    localparam logic [PIXEL_WIDTH-1:0] FLOOR_PX = PIXEL_WIDTH'(FLOOR_COLOR);
    localparam logic [PIXEL_WIDTH-1:0] WALL1_PX = PIXEL_WIDTH'(WALL1_COLOR);
    localparam logic [PIXEL_WIDTH-1:0] WALL2_PX = PIXEL_WIDTH'(WALL2_COLOR);

    localparam logic [9:0]        H_L      = 10'(SCREEN_HEIGHT);
    localparam logic [9:0]        HALF_H   = 10'(SCREEN_HEIGHT / 2);
    localparam logic [9:0]        SW_L     = 10'(SCREEN_WIDTH);
    localparam logic [7:0]        LAST_ROW = 8'(SCREEN_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        FLATTEN,
        TEX_WAIT,
        WAIT_SWAP
    } state_t;

    state_t state_q, state_n;

    logic [7:0]             vcount_q, vcount_n;
    logic [ADDR_W-1:0]      acc_q, acc_n;
    logic [8:0]             hcount_q;
    logic [7:0]             lh_q;
    logic                   wall_type_q;
    logic [3:0]             map_q;
    logic [15:0]            wallx_q;
    logic                   tlast_q;

    logic                   pix_valid_q, pix_valid_n;
    logic                   pix_last_q, pix_last_n;
    logic [ADDR_W-1:0]      pix_addr_q, pix_addr_n;
    logic [PIXEL_WIDTH-1:0] pix_data_q, pix_data_n;
    logic                   tex_req_q, tex_req_n;
    logic [8:0]             tex_yoff_q, tex_yoff_n;

    logic                   accept;
    logic                   do_write;
    logic [PIXEL_WIDTH-1:0] wr_px;

    // Row classification, all in 10-bit unsigned with explicit saturation so
    // the draw-start clamp at 0 and draw-end clamp at SCREEN_HEIGHT never wrap.
    logic [9:0]             half10, ds10, sum10, de10, vc10;
    logic                   row_ceil, row_floor, row_tex, offscreen, last_row;
    logic                   wall_shade;
    logic                   unused_ok;
    logic [PIXEL_WIDTH-1:0] wall_base, wall_px, tex_px, row_px;

    assign half10    = {3'b000, lh_q[7:1]};
    assign ds10      = (half10 >= HALF_H) ? 10'd0 : (HALF_H - half10);
    assign sum10     = HALF_H + half10;
    assign de10      = (sum10 >= H_L) ? H_L : sum10;
    assign vc10      = {2'b00, vcount_q};
    assign row_ceil  = (vc10 < ds10);
    assign row_floor = (vc10 >= de10);
    assign row_tex   = !row_ceil && !row_floor && (int'({28'd0, map_q}) >= TEX_BASE);
    assign offscreen = ({1'b0, hcount_q} >= SW_L);
    assign last_row  = (vcount_q == LAST_ROW);
    assign accept    = (state_q == IDLE) && col_tvalid_in;

`ifdef COLFLAT_SHADE_EN
    assign wall_shade = wall_type_q;
    assign unused_ok  = lh_q[0];
`else
    assign wall_shade = 1'b0;
    assign unused_ok  = lh_q[0] ^ wall_type_q;
`endif

    always_comb begin
        wall_base = WALL1_PX;
        case (map_q)
            4'd0:    wall_base = CEIL_PX;
            4'd1:    wall_base = WALL1_PX;
            4'd2:    wall_base = WALL2_PX;
            default: wall_base = WALL1_PX;
        endcase
    end

    assign wall_px = wall_shade ? (wall_base >> 1) : wall_base;
    assign tex_px  = wall_shade ? (tex_pixel_in >> 1) : tex_pixel_in;
    assign row_px  = row_ceil ? CEIL_PX : (row_floor ? FLOOR_PX : wall_px);

    always_comb begin
        state_n     = state_q;
        vcount_n    = vcount_q;
        acc_n       = acc_q;
        pix_valid_n = 1'b0;
        pix_last_n  = 1'b0;
        pix_addr_n  = pix_addr_q;
        pix_data_n  = pix_data_q;
        tex_req_n   = 1'b0;
        tex_yoff_n  = tex_yoff_q;
        do_write    = 1'b0;
        wr_px       = row_px;

        case (state_q)
            IDLE: begin
                if (col_tvalid_in) begin
                    state_n  = FLATTEN;
                    vcount_n = 8'd0;
                    acc_n    = ADDR_W'(col_tdata_in[37:29]);
                end
            end
            FLATTEN: begin
                if (offscreen) begin
                    // Column lies past the right edge: consume it in one cycle.
                    pix_last_n = tlast_q;
                    state_n    = tlast_q ? WAIT_SWAP : IDLE;
                end else if (row_tex) begin
                    tex_req_n  = 1'b1;
                    // Unclipped offset, so tall walls start mid-texture.
                    tex_yoff_n = 9'(vc10 + half10 - HALF_H);
                    state_n    = TEX_WAIT;
                end else begin
                    do_write = 1'b1;
                end
            end
            TEX_WAIT: begin
                if (tex_valid_in) begin
                    do_write = 1'b1;
                    wr_px    = tex_px;
                end
            end
            WAIT_SWAP: begin
                if (fb_ready_to_switch_in == 2'b11) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_write) begin
            pix_valid_n = 1'b1;
            pix_addr_n  = acc_q;
            pix_data_n  = wr_px;
            if (last_row) begin
                pix_last_n = tlast_q;
                state_n    = tlast_q ? WAIT_SWAP : IDLE;
            end else begin
                vcount_n = vcount_q + 8'd1;
                acc_n    = acc_q + ROW_STEP;
                state_n  = FLATTEN;
            end
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            vcount_q    <= '0;
            acc_q       <= '0;
            hcount_q    <= '0;
            lh_q        <= '0;
            wall_type_q <= 1'b0;
            map_q       <= '0;
            wallx_q     <= '0;
            tlast_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            pix_addr_q  <= '0;
            pix_data_q  <= '0;
            tex_req_q   <= 1'b0;
            tex_yoff_q  <= '0;
        end else begin
            state_q     <= state_n;
            vcount_q    <= vcount_n;
            acc_q       <= acc_n;
            pix_valid_q <= pix_valid_n;
            pix_last_q  <= pix_last_n;
            pix_addr_q  <= pix_addr_n;
            pix_data_q  <= pix_data_n;
            tex_req_q   <= tex_req_n;
            tex_yoff_q  <= tex_yoff_n;
            if (accept) begin
                hcount_q    <= col_tdata_in[37:29];
                lh_q        <= col_tdata_in[28:21];
                wall_type_q <= col_tdata_in[20];
                map_q       <= col_tdata_in[19:16];
                wallx_q     <= col_tdata_in[15:0];
                tlast_q     <= col_tlast_in;
            end
        end
    end

    assign col_tready_out = (state_q == IDLE);
    assign tex_req_out    = tex_req_q;
    assign tex_id_out     = map_q;
    assign tex_wallx_out  = wallx_q;
    assign tex_yoff_out   = tex_yoff_q;
    assign pix_valid_out  = pix_valid_q;
    assign pix_addr_out   = pix_addr_q;
    assign pix_data_out   = pix_data_q;
    assign pix_last_out   = pix_last_q;

endmodule

// File: tb/tb_column_flattener.sv
module tb_column_flattener;

    localparam int H = 180;
    localparam int W = 320;

`ifdef COLFLAT_SHADE_EN
    localparam logic [7:0] SHADED_W1 = 8'h7f;
`else
    localparam logic [7:0] SHADED_W1 = 8'hff;
`endif

    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    logic        col_tvalid_in;
    logic [37:0] col_tdata_in;
    logic        col_tlast_in;
    logic        col_tready_out;
    logic [1:0]  fb_ready_to_switch_in;
    logic        tex_req_out;
    logic [3:0]  tex_id_out;
    logic [15:0] tex_wallx_out;
    logic [8:0]  tex_yoff_out;
    logic        tex_valid_in;
    logic [7:0]  tex_pixel_in;
    logic        pix_valid_out;
    logic [15:0] pix_addr_out;
    logic [7:0]  pix_data_out;
    logic        pix_last_out;

    always #5 pixel_clk_in = ~pixel_clk_in;

    column_flattener dut (
        .pixel_clk_in          (pixel_clk_in),
        .rst_in                (rst_in),
        .col_tvalid_in         (col_tvalid_in),
        .col_tdata_in          (col_tdata_in),
        .col_tlast_in          (col_tlast_in),
        .col_tready_out        (col_tready_out),
        .fb_ready_to_switch_in (fb_ready_to_switch_in),
        .tex_req_out           (tex_req_out),
        .tex_id_out            (tex_id_out),
        .tex_wallx_out         (tex_wallx_out),
        .tex_yoff_out          (tex_yoff_out),
        .tex_valid_in          (tex_valid_in),
        .tex_pixel_in          (tex_pixel_in),
        .pix_valid_out         (pix_valid_out),
        .pix_addr_out          (pix_addr_out),
        .pix_data_out          (pix_data_out),
        .pix_last_out          (pix_last_out)
    );

    int checks   = 0;
    int failures = 0;

    int cycle = 0;
    always @(posedge pixel_clk_in) cycle <= cycle + 1;

    // results of the most recent collect()
    int          nwr, nlast, nlast_nowr, last_row, nreq, late_wr, nserved;
    int          first_wr_cyc, last_wr_cyc, first_yoff, acc_cyc;
    logic        tready_at_last;
    logic [3:0]  first_tid;
    logic [15:0] first_twx;
    logic [15:0] addr_a [H];
    logic [7:0]  data_a [H];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_col(input logic [8:0] hc, input logic [7:0] lh, input logic wt,
                            input logic [3:0] md, input logic tl, input logic [15:0] wx);
        int n = 0;
        while (col_tready_out !== 1'b1 && n < 400) begin
            @(negedge pixel_clk_in);
            n++;
        end
        if (col_tready_out !== 1'b1) check("accept_ready", col_tready_out, 1'b1);
        col_tvalid_in = 1'b1;
        col_tdata_in  = {hc, lh, wt, md, wx};
        col_tlast_in  = tl;
        @(posedge pixel_clk_in);
        #1;
        acc_cyc       = cycle;
        col_tvalid_in = 1'b0;
        col_tlast_in  = 1'b0;
    endtask

    // Observes outputs at each falling edge; optionally answers every texel
    // request with tex_valid_in three cycles later (pixel n*7+3 for request n).
    task automatic collect(input int budget, input int stop_after, input bit serve_tex);
        int  cnt = 0;
        bit  tv_was;
        nwr = 0; nlast = 0; nlast_nowr = 0; last_row = -1; nreq = 0; late_wr = 0;
        nserved = 0; first_wr_cyc = -1; last_wr_cyc = -1; first_yoff = -1;
        tready_at_last = 1'bx;
        for (int cyc = 1; cyc <= budget && nwr < stop_after; cyc++) begin
            @(negedge pixel_clk_in);
            tv_was = tex_valid_in;
            if (pix_valid_out === 1'b1) begin
                if (nwr < H) begin
                    addr_a[nwr] = pix_addr_out;
                    data_a[nwr] = pix_data_out;
                end
                if (nwr == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                if (serve_tex && !tv_was) late_wr++;
                if (pix_last_out === 1'b1) last_row = nwr;
                tready_at_last = col_tready_out;
                nwr++;
            end
            if (pix_last_out === 1'b1) nlast++;
            if (pix_last_out === 1'b1 && pix_valid_out !== 1'b1) nlast_nowr++;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tex_valid_in = 1'b1;
                    tex_pixel_in = 8'(nserved * 7 + 3);
                    nserved++;
                end
            end else begin
                tex_valid_in = 1'b0;
            end
            if (tex_req_out === 1'b1) begin
                if (nreq == 0) begin
                    first_yoff = int'(tex_yoff_out);
                    first_tid  = tex_id_out;
                    first_twx  = tex_wallx_out;
                end
                nreq++;
                if (serve_tex) cnt = 3;
            end
        end
        tex_valid_in = 1'b0;
    endtask

    task automatic check_rows(input string tag, input int lo, input int hi, input logic [7:0] val);
        int bad = 0;
        for (int r = lo; r <= hi; r++) if (data_a[r] !== val) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_addrs(input string tag, input int hc);
        int bad = 0;
        for (int r = 0; r < H; r++) if (addr_a[r] !== 16'(hc + r * W)) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, bad;
        rst_in = 1'b1; col_tvalid_in = 1'b0; col_tdata_in = '0; col_tlast_in = 1'b0;
        fb_ready_to_switch_in = 2'b00; tex_valid_in = 1'b0; tex_pixel_in = '0;
        repeat (3) @(negedge pixel_clk_in);
        check("rst_tready", col_tready_out, 1'b1);
        check("rst_pix_valid", pix_valid_out, 1'b0);
        check("rst_pix_last", pix_last_out, 1'b0);
        check("rst_tex_req", tex_req_out, 1'b0);
        check("rst_pix_addr", pix_addr_out, 16'd0);
        check("rst_pix_data", pix_data_out, 8'd0);
        rst_in = 1'b0;

        // texel strobe while idle must not write
        tex_valid_in = 1'b1; tex_pixel_in = 8'h55;
        @(negedge pixel_clk_in);
        tex_valid_in = 1'b0;
        @(negedge pixel_clk_in);
        check("idle_tex_ignored", pix_valid_out, 1'b0);

        // basic column: ceiling / wall1 / floor
        send_col(9'd5, 8'd40, 1'b0, 4'd1, 1'b0, 16'h1234);
        a1 = acc_cyc;
        collect(400, H, 1'b0);
        check("c1_nwr", nwr, H);
        check("c1_addr0", addr_a[0], 16'd5);
        check("c1_addr179", addr_a[179], 16'd57285);
        check_addrs("c1_addr_bad", 5);
        check_rows("c1_ceil", 0, 69, 8'h2a);
        check_rows("c1_wall", 70, 109, 8'hff);
        check_rows("c1_floor", 110, 179, 8'hdc);
        check("c1_nlast", nlast, 0);
        check("c1_tready_end", tready_at_last, 1'b1);
        check("c1_first_cyc", first_wr_cyc, 2);
        check("c1_last_cyc", last_wr_cyc, 181);

        // back-to-back column, wall2
        send_col(9'd6, 8'd40, 1'b0, 4'd2, 1'b0, 16'h0);
        check("b2b_period", acc_cyc - a1, 181);
        collect(400, H, 1'b0);
        check("c2_nwr", nwr, H);
        check_addrs("c2_addr_bad", 6);
        check_rows("c2_wall", 70, 109, 8'h97);

        // last column of frame, swap not yet ready
        fb_ready_to_switch_in = 2'b01;
        send_col(9'd5, 8'd40, 1'b0, 4'd1, 1'b1, 16'h0);
        collect(400, H, 1'b0);
        check("c3_nlast", nlast, 1);
        check("c3_last_row", last_row, 179);
        check("c3_addr_last", addr_a[179], 16'd57285);
        check("c3_tready_end", tready_at_last, 1'b0);
        repeat (5) @(negedge pixel_clk_in);
        check("c3_swap_hold", col_tready_out, 1'b0);
        check("c3_no_write", pix_valid_out, 1'b0);
        fb_ready_to_switch_in = 2'b11;
        @(negedge pixel_clk_in);
        check("c3_swap_release", col_tready_out, 1'b1);
        fb_ready_to_switch_in = 2'b00;

        // textured, tall wall, texel 3 cycles after each request
        send_col(9'd10, 8'd200, 1'b0, 4'd4, 1'b0, 16'hbeef);
        collect(2000, H, 1'b1);
        check("tex_nreq", nreq, H);
        check("tex_first_yoff", first_yoff, 10);
        check("tex_id", first_tid, 4'd4);
        check("tex_wallx", first_twx, 16'hbeef);
        check("tex_nwr", nwr, H);
        check("tex_late_wr", late_wr, 0);
        check_addrs("tex_addr_bad", 10);
        bad = 0;
        for (int r = 0; r < H; r++) if (data_a[r] !== 8'(r * 7 + 3)) bad++;
        check("tex_data_bad", bad, 0);

        // lineHeight boundaries
        send_col(9'd0, 8'd0, 1'b0, 4'd1, 1'b0, 16'h0);
        collect(400, H, 1'b0);
        check_rows("lh0_ceil", 0, 89, 8'h2a);
        check_rows("lh0_floor", 90, 179, 8'hdc);
        check_addrs("lh0_addr_bad", 0);
        send_col(9'd1, 8'd1, 1'b0, 4'd1, 1'b0, 16'h0);
        collect(400, H, 1'b0);
        check_rows("lh1_ceil", 0, 89, 8'h2a);
        check_rows("lh1_floor", 90, 179, 8'hdc);
        send_col(9'd1, 8'd255, 1'b0, 4'd2, 1'b0, 16'h0);
        collect(400, H, 1'b0);
        check_rows("lh255_wall", 0, 179, 8'h97);
        send_col(9'd319, 8'd180, 1'b0, 4'd1, 1'b0, 16'h0);
        collect(400, H, 1'b0);
        check_rows("lh180_wall", 0, 179, 8'hff);
        check("lh180_addr179", addr_a[179], 16'd57599);

        // wallType set: shaded walls only when the shade build is selected
        send_col(9'd5, 8'd40, 1'b1, 4'd1, 1'b0, 16'h0);
        collect(400, H, 1'b0);
        check_rows("shade_ceil", 0, 69, 8'h2a);
        check_rows("shade_wall", 70, 109, SHADED_W1);
        check_rows("shade_floor", 110, 179, 8'hdc);

        // off-screen columns
        send_col(9'd320, 8'd40, 1'b0, 4'd1, 1'b1, 16'h0);
        collect(6, 1, 1'b0);
        check("off_last_nwr", nwr, 0);
        check("off_last_pulse", nlast, 1);
        check("off_last_nowr", nlast_nowr, 1);
        check("off_last_tready", col_tready_out, 1'b0);
        fb_ready_to_switch_in = 2'b11;
        @(negedge pixel_clk_in);
        check("off_swap_release", col_tready_out, 1'b1);
        fb_ready_to_switch_in = 2'b00;
        send_col(9'd400, 8'd40, 1'b0, 4'd1, 1'b0, 16'h0);
        collect(6, 1, 1'b0);
        check("off_nwr", nwr, 0);
        check("off_nlast", nlast, 0);
        check("off_tready", col_tready_out, 1'b1);

        // reset at row 50, then a fresh column
        send_col(9'd5, 8'd40, 1'b0, 4'd1, 1'b0, 16'h0);
        collect(400, 51, 1'b0);
        check("mid_rst_rows", nwr, 51);
        rst_in = 1'b1;
        @(negedge pixel_clk_in);
        check("mid_rst_tready", col_tready_out, 1'b1);
        check("mid_rst_valid", pix_valid_out, 1'b0);
        rst_in = 1'b0;
        send_col(9'd7, 8'd40, 1'b0, 4'd2, 1'b0, 16'h0);
        collect(400, H, 1'b0);
        check("after_rst_nwr", nwr, H);
        check("after_rst_addr0", addr_a[0], 16'd7);
        check_rows("after_rst_wall", 70, 109, 8'h97);

        // reset while waiting for a texel
        send_col(9'd5, 8'd200, 1'b0, 4'd4, 1'b0, 16'h0);
        collect(4, 1, 1'b0);
        check("texwait_req_seen", nreq, 1);
        rst_in = 1'b1;
        @(negedge pixel_clk_in);
        check("texwait_rst_tready", col_tready_out, 1'b1);
        check("texwait_rst_req", tex_req_out, 1'b0);
        check("texwait_rst_yoff", tex_yoff_out, 9'd0);
        rst_in = 1'b0;
        tex_valid_in = 1'b1;
        @(negedge pixel_clk_in);
        tex_valid_in = 1'b0;
        @(negedge pixel_clk_in);
        check("texwait_stale_texel", pix_valid_out, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
